ext_mem_arbiter: RTL
====================

# ext_mem_arbiter

Shares the single external partial-sum memory (one read port, one write port, 1-cycle read latency) between two requesters: requester 0, the convolution controller's partial-sum read/writeback path, and requester 1, the output drain/host readback path. Each requester gets a valid/ready request channel and a read-response channel. Grants use round-robin. A lock lets a requester keep a read-modify-write sequence atomic, and a lock timeout bounds how long it can hold the memory.

## Interface
Parameters:
- ADDR_WIDTH, 20, external memory address width ($clog2 of memory height)
- DATA_WIDTH, 32, memory word width (accumulation width)
- MAX_LOCK_CYCLES, 16, maximum consecutive cycles spent in LOCKED before forced release (≥2)

Ports (N = 0, 1):
- clk  in  1  single clock, rising edge
- arst_n_in  in  1  asynchronous active-low reset
- rN_req_valid  in  1  request present
- rN_req_ready  out  1  request accepted this cycle (handshake = valid & ready)
- rN_req_we  in  1  1 = write, 0 = read
- rN_req_addr  in  ADDR_WIDTH  word address
- rN_req_wdata  in  DATA_WIDTH  write data
- rN_req_lock  in  1  hold the grant after this transaction
- rN_rsp_valid  out  1  read data valid for requester N
- rN_rsp_data  out  DATA_WIDTH  read data
- ext_mem_read_en  out  1  memory read strobe
- ext_mem_read_addr  out  ADDR_WIDTH  memory read address
- ext_mem_qout  in  DATA_WIDTH  memory read data, valid the cycle after read_en
- ext_mem_write_en  out  1  memory write strobe
- ext_mem_write_addr  out  ADDR_WIDTH  memory write address
- ext_mem_din  out  DATA_WIDTH  memory write data
- lock_timeout  out  1  one-cycle pulse on forced lock release
- grant_owner  out  1  requester granted this cycle (valid only while a handshake occurs)

## Operation
- At most one transaction per cycle overall. A read and a write are never issued in the same cycle.
- State machine has two states:
  - IDLE. Arbitration among valid requesters.
    - One valid requester: it is granted.
    - Both valid: grant the requester ≠ last_grant.
    - last_grant updates on every handshake.
  - LOCKED(owner). Only the owner's ready may be high; the other requester's ready = 0.
- IDLE→LOCKED(N): on a handshake from N with rN_req_lock = 1.
- LOCKED→IDLE when either:
  - the owner's handshake has lock = 0, or
  - the timeout expires.
- Owner idling (valid = 0) in LOCKED does not release the lock.
- Lock counter:
  - Cleared on entry to LOCKED; increments every LOCKED cycle.
  - A lock = 1 handshake inside LOCKED does not clear it.
  - When the counter = MAX_LOCK_CYCLES−1, the owner may still handshake that cycle. Next state is IDLE regardless of lock.
  - lock_timeout is high that cycle unless the owner's handshake there has lock = 0.
  - last_grant = owner, so the other requester wins the next tie.
- Memory drive on a handshake:
  - Write: write_en = 1, write_addr/din = granted addr/wdata.
  - Read: read_en = 1, read_addr = granted addr.
  - Strobes are 0 without a handshake.
- Response routing:
  - A 1-bit registered tag and a registered pending flag record each read.
  - The cycle after a read, rN_rsp_valid = 1 for the tagged requester only.
  - rN_rsp_data = ext_mem_qout (combinational) for both N. Data is meaningful only with valid.
  - Responses have no backpressure; requesters must accept them.
- Memory semantics: a write at cycle t is visible to a read issued at t+1. The arbiter adds no forwarding.

## Timing
- Grant is combinational: ready depends on the current-cycle valid signals and the registered state. Memory strobes are asserted in the handshake cycle.
- Read latency: request handshake at t, rsp_valid at t+1.
- Back-to-back reads from either requester are allowed every cycle.
- Reset (asynchronous, any time, including mid-lock or with a read in flight):
  - state = IDLE, counter = 0, last_grant = 1 (requester 0 wins the first tie), pending = 0.
  - All ready/strobe/rsp_valid/lock_timeout outputs = 0; grant_owner = 0.
  - A response in flight is dropped.
- Outputs during reset are all 0 regardless of inputs.

## Test plan
- Reset, then r0 and r1 both request reads continuously (addr 0x10 and 0x20) → grants alternate 0,1,0,1. Each rsp_valid appears on the correct port one cycle later with that port's word.
- r0 writes 0xDEADBEEF to 0x5 at t, r1 reads 0x5 at t+1 → r1_rsp_valid at t+2 with data 0xDEADBEEF; r0_rsp_valid stays 0.
- r0 reads 0x7 with lock = 1, then writes 0x7 with lock = 0 two cycles later; r1 requests throughout → r1_req_ready = 0 until after the write, then r1 is granted the next cycle.
- r0 locks and holds lock = 1 with MAX_LOCK_CYCLES = 16 → r1 is blocked exactly 16 cycles after entry. lock_timeout pulses once, then r1 is granted.
- Assert arst_n_in during LOCKED with a read in flight → no rsp_valid after reset. After release, the first tie goes to r0 and the state is IDLE.
- Single requester r1 issues a read every cycle, r0 idle → r1_req_ready is constantly 1 and throughput is 1 read/cycle.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// Two-requester round-robin arbiter for the shared external partial-sum memory,
// with an atomic lock (bounded by MAX_LOCK_CYCLES) and 1-cycle read response routing.
module ext_mem_arbiter #(
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_LOCK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  r0_req_valid,
   output logic                  r0_req_ready,
   input  logic                  r0_req_we,
   input  logic [ADDR_WIDTH-1:0] r0_req_addr,
   input  logic [DATA_WIDTH-1:0] r0_req_wdata,
   input  logic                  r0_req_lock,
   output logic                  r0_rsp_valid,
   output logic [DATA_WIDTH-1:0] r0_rsp_data,
   input  logic                  r1_req_valid,
   output logic                  r1_req_ready,
   input  logic                  r1_req_we,
   input  logic [ADDR_WIDTH-1:0] r1_req_addr,
   input  logic [DATA_WIDTH-1:0] r1_req_wdata,
   input  logic                  r1_req_lock,
   output logic                  r1_rsp_valid,
   output logic [DATA_WIDTH-1:0] r1_rsp_data,
   output logic                  ext_mem_read_en,
   output logic [ADDR_WIDTH-1:0] ext_mem_read_addr,
   input  logic [DATA_WIDTH-1:0] ext_mem_qout,
   output logic                  ext_mem_write_en,
   output logic [ADDR_WIDTH-1:0] ext_mem_write_addr,
   output logic [DATA_WIDTH-1:0] ext_mem_din,
   output logic                  lock_timeout,
   output logic                  grant_owner
);
   localparam int CW = (MAX_LOCK_CYCLES > 2) ? $clog2(MAX_LOCK_CYCLES) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic            owner, last_grant, pend, tag;
   logic [CW-1:0]   lock_cnt;

   logic                  grant, req_any, hs, sel_we, sel_lock, at_limit;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Grant is purely combinational on current valids plus registered state.
   always_comb begin
      grant   = 1'b0;
      req_any = 1'b0;
      if (state == LOCKED) begin
         grant   = owner;
         req_any = owner ? r1_req_valid : r0_req_valid;
      end else if (r0_req_valid && r1_req_valid) begin
         grant   = ~last_grant;
         req_any = 1'b1;
      end else begin
         grant   = r1_req_valid;
         req_any = r0_req_valid | r1_req_valid;
      end
   end

   assign hs        = req_any & arst_n_in;
   assign sel_we    = grant ? r1_req_we    : r0_req_we;
   assign sel_lock  = grant ? r1_req_lock  : r0_req_lock;
   assign sel_addr  = grant ? r1_req_addr  : r0_req_addr;
   assign sel_wdata = grant ? r1_req_wdata : r0_req_wdata;
   assign at_limit  = (state == LOCKED) && (lock_cnt == CW'(MAX_LOCK_CYCLES - 1));

   assign r0_req_ready       = hs & ~grant;
   assign r1_req_ready       = hs & grant;
   assign grant_owner        = hs & grant;
   assign ext_mem_read_en    = hs & ~sel_we;
   assign ext_mem_write_en   = hs & sel_we;
   assign ext_mem_read_addr  = arst_n_in ? sel_addr  : '0;
   assign ext_mem_write_addr = arst_n_in ? sel_addr  : '0;
   assign ext_mem_din        = arst_n_in ? sel_wdata : '0;
   // A lock=0 handshake on the final cycle is a normal release, not a timeout.
   assign lock_timeout       = at_limit & ~(hs & ~sel_lock) & arst_n_in;

   assign r0_rsp_valid = pend & ~tag & arst_n_in;
   assign r1_rsp_valid = pend & tag & arst_n_in;
   assign r0_rsp_data  = arst_n_in ? ext_mem_qout : '0;
   assign r1_rsp_data  = arst_n_in ? ext_mem_qout : '0;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         pend       <= 1'b0;
         tag        <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         pend <= hs & ~sel_we;
         tag  <= grant;
         if (hs) last_grant <= grant;
         if (state == IDLE) begin
            if (hs && sel_lock) begin
               state    <= LOCKED;
               owner    <= grant;
               lock_cnt <= '0;
            end
         end else begin
            lock_cnt <= lock_cnt + 1'b1;
            if (at_limit) begin
               state      <= IDLE;
               last_grant <= owner;
            end else if (hs && !sel_lock) begin
               state <= IDLE;
            end
         end
      end
   end
endmodule
